// File: rtl/lut4_config_sequencer.sv
// Purpose: shift a 16-entry truth table in serially, then write it into one LUT4 cell.
// Latency: 49 cycles from start to done when the stream never stalls; the write phase is always 32 cycles.
// Backpressure: o_ser_ready is high only in SHIFT, and a low i_ser_valid stalls the pass one cycle at a time.
module lut4_config_sequencer #(
  parameter int LUT_BITS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_ser_data,
  input  logic              i_ser_valid,
  output logic              o_ser_ready,
  output logic [ADDR_W-1:0] o_addr_load_data,
  output logic              o_Data,
  output logic              o_config_enable,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LUT_BITS - 1);

  logic [2:0]          state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [LUT_BITS-1:0] shadow_q, shadow_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic                data_q,   data_d;
  logic                en_q,     en_d;

  logic [ADDR_W-1:0]   idx;
  assign idx = cnt_q[ADDR_W-1:0];

  // Next-state logic. SETUP presents address/data with the strobe low, and
  // STROBE only raises the strobe, so the address and data never move while
  // the strobe is high. Abort overrides every transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    addr_d   = addr_q;
    data_d   = data_q;
    en_d     = en_q;
    case (state_q)
      S_IDLE: begin
        en_d = 1'b0;
        if (i_start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (i_ser_valid) begin
          shadow_d[idx] = i_ser_data;
          if (cnt_q == CNT_LAST) begin
            state_d = S_SETUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_SETUP: begin
        addr_d  = idx;
        data_d  = shadow_q[idx];
        en_d    = 1'b0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        en_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_SETUP;
        end
      end
      S_DONE: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // The shadow register keeps its contents on abort, so a later pass can be
    // compared against what was shifted in.
    if (i_abort) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      en_d     = 1'b0;
      shadow_d = shadow_q;
      addr_d   = addr_q;
      data_d   = data_q;
    end
  end

  // State, shadow and LUT-port registers; reset clears everything at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      addr_q   <= '0;
      data_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      en_q     <= en_d;
    end
  end

  assign o_addr_load_data = addr_q;
  assign o_Data           = data_q;
  assign o_config_enable  = en_q;
  assign o_ser_ready      = (state_q == S_SHIFT);
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = (state_q == S_DONE);

endmodule

// File: tb/tb_lut4_config_sequencer.sv
// Directed bench for lut4_config_sequencer: reset, full loads, stalls, abort, spurious starts.
// A negedge monitor records every strobed (address, data) pair and every done pulse.
// The main block drives inputs just after each falling edge and checks against hand-computed values.
module tb_lut4_config_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       i_abort;
  logic       i_ser_data;
  logic       i_ser_valid;
  logic       o_ser_ready;
  logic [3:0] o_addr_load_data;
  logic       o_Data;
  logic       o_config_enable;
  logic       o_busy;
  logic       o_done;

  lut4_config_sequencer #(.LUT_BITS(16), .ADDR_W(4)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_ser_data       (i_ser_data),
    .i_ser_valid      (i_ser_valid),
    .o_ser_ready      (o_ser_ready),
    .o_addr_load_data (o_addr_load_data),
    .o_Data           (o_Data),
    .o_config_enable  (o_config_enable),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Rising-edge count; read on the falling edge it equals the number of the last edge.
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: log each strobe cycle and check it follows a stable, strobe-low cycle.
  logic [3:0] wr_addr [0:511];
  logic       wr_data [0:511];
  int         wr_total   = 0;
  int         done_total = 0;
  int         done_cyc   = 0;
  int         glitch     = 0;
  logic       en_p   = 1'b0;
  logic [3:0] addr_p = '0;
  logic       data_p = 1'b0;
  always @(negedge i_clk) begin
    if (o_config_enable === 1'b1) begin
      if (!(en_p === 1'b0 && addr_p === o_addr_load_data && data_p === o_Data)) glitch++;
      if (wr_total < 512) begin
        wr_addr[wr_total] = o_addr_load_data;
        wr_data[wr_total] = o_Data;
      end
      wr_total++;
    end
    if (o_done === 1'b1) begin
      done_total++;
      done_cyc = cyc;
    end
    en_p   = o_config_enable;
    addr_p = o_addr_load_data;
    data_p = o_Data;
  end

  int start_cyc, wr_base, done_base, glitch_base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  // Start a pass and stream w LSB-first; optional stall every third cycle and
  // an optional spurious start while shifting.
  task automatic feed(input logic [15:0] w, input bit stall, input bit spur);
    int i;
    int k;
    i = 0;
    k = 0;
    i_start = 1'b1;
    tick();
    i_start     = 1'b0;
    start_cyc   = cyc;
    wr_base     = wr_total;
    done_base   = done_total;
    glitch_base = glitch;
    while (i < 16) begin
      if (stall && (k % 3 == 2)) begin
        i_ser_valid = 1'b0;
        i_ser_data  = 1'b1;
      end else begin
        i_ser_valid = 1'b1;
        i_ser_data  = w[i];
        i++;
      end
      i_start = spur && (k == 4);
      k++;
      tick();
    end
    i_ser_valid = 1'b0;
    i_start     = 1'b0;
  endtask

  // Wait for done, then check latency (in edges after the start edge) and the write sequence.
  task automatic finish_pass(input string tag, input logic [15:0] w, input int exp_lat, input bit spur);
    logic [15:0] got;
    bit          seq_ok;
    for (int j = 0; j < 200 && done_total == done_base; j++) begin
      i_ser_valid = j[0];
      i_ser_data  = 1'b1;
      i_start     = spur && (j == 10);
      tick();
    end
    i_ser_valid = 1'b0;
    i_start     = 1'b0;
    chk({tag, " done_pulses"}, done_total - done_base, 1);
    chk({tag, " latency"}, done_cyc - start_cyc, exp_lat);
    chk({tag, " write_count"}, wr_total - wr_base, 16);
    got    = '0;
    seq_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      got[i] = wr_data[wr_base + i];
      if (wr_addr[wr_base + i] !== 4'(i)) seq_ok = 1'b0;
    end
    chk({tag, " written_data"}, got, w);
    chk({tag, " address_order"}, seq_ok, 1);
    chk({tag, " glitch_free"}, glitch - glitch_base, 0);
    tick();
    chk({tag, " idle_after_done"}, {o_busy, o_done, o_config_enable}, 3'b000);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_abort     = 1'b0;
    i_ser_data  = 1'b0;
    i_ser_valid = 1'b0;
    #1;
    chk("reset_outputs", {o_addr_load_data, o_Data, o_config_enable, o_ser_ready, o_busy, o_done}, 9'h0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();

    // Reset asserted while a strobe is high clears every output at once.
    feed(16'h1234, 1'b0, 1'b0);
    for (int j = 0; j < 60 && o_config_enable !== 1'b1; j++) tick();
    chk("strobe_reached", o_config_enable, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("reset_mid_strobe", {o_addr_load_data, o_Data, o_config_enable, o_ser_ready, o_busy, o_done}, 9'h0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Idle with a toggling serial valid: nothing is consumed or written.
    wr_base = wr_total;
    for (int j = 0; j < 8; j++) begin
      i_ser_valid = j[0];
      i_ser_data  = 1'b1;
      tick();
    end
    i_ser_valid = 1'b0;
    chk("idle_no_writes", wr_total - wr_base, 0);
    chk("idle_ser_ready", o_ser_ready, 1'b0);
    chk("idle_busy", o_busy, 1'b0);

    // Full load, valid always high: done 48 edges after the start edge (49th cycle).
    feed(16'h8001, 1'b0, 1'b0);
    finish_pass("load_8001", 16'h8001, 48, 1'b0);

    // Stalled stream: 16 accepts with a stall every third cycle take 23 cycles, i.e. 7 stalls.
    feed(16'hA5C3, 1'b1, 1'b0);
    finish_pass("stall_A5C3", 16'hA5C3, 55, 1'b0);

    // Abort while entry 6 is strobed: strobe drops, pass ends with no done.
    feed(16'h5A5A, 1'b0, 1'b0);
    for (int j = 0; j < 100 && (wr_total - wr_base) != 7; j++) tick();
    chk("abort_reached_entry6", wr_total - wr_base, 7);
    chk("abort_entry6_addr", o_addr_load_data, 4'd6);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_outputs", {o_config_enable, o_busy, o_ser_ready}, 3'b000);
    for (int j = 0; j < 60; j++) tick();
    chk("abort_no_done", done_total - done_base, 0);
    chk("abort_no_more_writes", wr_total - wr_base, 7);

    // Fresh pass after the abort completes normally.
    feed(16'hFFFF, 1'b0, 1'b0);
    finish_pass("after_abort_FFFF", 16'hFFFF, 48, 1'b0);

    // Spurious starts in SHIFT and in the write phase change nothing.
    feed(16'h3C96, 1'b0, 1'b1);
    finish_pass("spurious_3C96", 16'h3C96, 48, 1'b1);

    // Start and abort together in IDLE: abort wins.
    i_start = 1'b1;
    i_abort = 1'b1;
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("start_abort_busy", o_busy, 1'b0);
    chk("start_abort_ready", o_ser_ready, 1'b0);
    tick();
    chk("start_abort_still_idle", {o_busy, o_config_enable}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
